// File: rtl/debounce_pkg.sv
// debounce_pkg: shared defaults and sizing helpers for the switch debouncer
package debounce_pkg;
  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;
  function automatic int cnt_width(input int cycles);
    return $clog2(cycles);
  endfunction
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one switch synchroniser, debounce counter and edge strobe pair
module debounce_channel import debounce_pkg::*; #(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);
  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0] cnt;
  logic sync;
  assign sync = sync_q[SYNC_STAGES-1];
  // shift the asynchronous pin through the synchroniser chain
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= {sync_q[SYNC_STAGES-2:0], raw};
  // accept a new level only after it has differed from db for DEBOUNCE_CYCLES edges
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      db <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (sync == db) cnt <= '0;
      else if (cnt == CNT_MAX) begin
        cnt <= '0;
        db <= sync;
        rise <= sync;
        fall <= ~sync;
      end else cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: per-switch synchronise/debounce with edge strobes and start-up valid
module switch_debouncer import debounce_pkg::*; #(
  parameter int N_SW = 5,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_db,
  output logic [N_SW-1:0] sw_rise,
  output logic [N_SW-1:0] sw_fall,
  output logic            sw_valid
);
  localparam int SETTLE = SYNC_STAGES + DEBOUNCE_CYCLES;
  localparam int SW_W = $clog2(SETTLE + 1);
  localparam logic [SW_W-1:0] SU_LAST = SW_W'(SETTLE - 1);
  logic [SW_W-1:0] su;
  for (genvar i = 0; i < N_SW; i++) begin : g_ch
    debounce_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .raw(sw_raw[i]),
      .db(sw_db[i]),
      .rise(sw_rise[i]),
      .fall(sw_fall[i])
    );
  end
  // count edges since reset release and latch valid once a full settle time has passed
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      su <= '0;
      sw_valid <= 1'b0;
    end else if (!sw_valid) begin
      su <= su + 1'b1;
      sw_valid <= su == SU_LAST;
    end
endmodule

// File: tb/tb_switch_debouncer.sv
// tb_switch_debouncer: directed and random checks against a raw-history window model
module tb_switch_debouncer;
  localparam int N = 5, S = 2, D = 8, L = S + D, HN = 8192;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] sw_raw = '0, sw_db, sw_rise, sw_fall;
  logic sw_valid;
  int n_cmp = 0, n_bad = 0;
  logic [N-1:0] hist [0:HN-1];
  int ecount;
  logic [N-1:0] db_m, rise_m, fall_m;
  logic valid_m;
  int lat, nr, nf, nchg;
  logic seen;
  logic [N-1:0] v;

  switch_debouncer #(.N_SW(N), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .sw_raw(sw_raw), .sw_db(sw_db),
    .sw_rise(sw_rise), .sw_fall(sw_fall), .sw_valid(sw_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ecount = 0;
    db_m = '0;
    rise_m = '0;
    fall_m = '0;
    valid_m = 1'b0;
  endtask

  function automatic logic raw_at(input int k, input int i);
    return (k >= 1) ? hist[k % HN][i] : 1'b0;
  endfunction

  // drive one raw value for one clock edge; the model flips a level when the raw
  // pin seen S..L-1 edges ago disagreed with it for all D consecutive samples
  task automatic step(input logic [N-1:0] val);
    logic stable;
    sw_raw = val;
    @(posedge clk);
    #1;
    ecount++;
    hist[ecount % HN] = val;
    rise_m = '0;
    fall_m = '0;
    for (int i = 0; i < N; i++) begin
      stable = 1'b1;
      for (int j = S; j < L; j++) if (raw_at(ecount - j, i) == db_m[i]) stable = 1'b0;
      if (stable) begin
        db_m[i] = ~db_m[i];
        rise_m[i] = db_m[i];
        fall_m[i] = ~db_m[i];
      end
    end
    valid_m = ecount >= L;
    chk("db", sw_db, db_m);
    chk("rise", sw_rise, rise_m);
    chk("fall", sw_fall, fall_m);
    chk("valid", sw_valid, valid_m);
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    sw_raw = 5'b11111;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("in_reset", {sw_db, sw_rise, sw_fall, sw_valid}, 0);
    end
    rst_n = 1'b1;
    model_reset();
    for (int k = 1; k <= 12; k++) begin
      step(5'b11111);
      if (k == 9) chk("startup_valid_e9", sw_valid, 0);
      if (k == 10) chk("startup_e10", {sw_db, sw_rise, sw_valid}, {5'b11111, 5'b11111, 1'b1});
    end
    for (int k = 0; k < 12; k++) step(5'b00000);
    lat = 0; nr = 0; nf = 0;
    for (int k = 1; k <= 14; k++) begin
      step(5'b00001);
      if (sw_db[0] && lat == 0) lat = k;
      nr += int'(sw_rise[0]);
      nf += int'(|sw_fall);
    end
    chk("press_lat", lat, 10);
    chk("press_rise_cnt", nr, 1);
    chk("press_fall_cnt", nf, 0);
    nchg = 0;
    for (int c = 0; c < 30; c++) begin
      v = 5'b00001;
      v[2] = ((c / 3) % 2) == 0;
      step(v);
      nchg += int'(sw_rise[2] | sw_fall[2]);
    end
    chk("bounce_no_change", nchg, 0);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      step(5'b00101);
      if (sw_db[2] && lat == 0) lat = k;
    end
    chk("bounce_lat", lat, 10);
    nr = 0; nf = 0;
    for (int k = 0; k < 7; k++) begin step(5'b00111); nr += int'(sw_rise[1]); end
    for (int k = 0; k < 12; k++) begin step(5'b00101); nr += int'(sw_rise[1]); nf += int'(sw_fall[1]); end
    chk("glitch7_rise", nr, 0);
    chk("glitch7_fall", nf, 0);
    nr = 0; nf = 0; lat = 0;
    for (int k = 0; k < 8; k++) begin step(5'b00111); nr += int'(sw_rise[1]); end
    for (int k = 0; k < 20; k++) begin
      step(5'b00101);
      nr += int'(sw_rise[1]);
      nf += int'(sw_fall[1]);
      lat += int'(sw_db[1]);
    end
    chk("glitch8_rise", nr, 1);
    chk("glitch8_fall", nf, 1);
    chk("glitch8_width", lat, 8);
    for (int k = 0; k < 12; k++) step(5'b00000);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin step(5'b10101); seen |= (sw_rise == 5'b10101); end
    chk("simul_rise", seen, 1);
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin step(5'b00000); seen |= (sw_fall == 5'b10101); end
    chk("simul_fall", seen, 1);
    v = '0;
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(0, 9) == 0) v[i] = ~v[i];
      step(v);
    end
    for (int k = 0; k < 12; k++) step(5'b00001);
    for (int k = 0; k < 7; k++) step(5'b01001);
    rst_n = 1'b0;
    #1;
    chk("midreset_clear", {sw_db, sw_rise, sw_fall, sw_valid}, 0);
    @(negedge clk);
    @(negedge clk);
    chk("midreset_hold", {sw_db, sw_rise, sw_fall, sw_valid}, 0);
    rst_n = 1'b1;
    model_reset();
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      step(5'b01000);
      if (sw_db[3] && lat == 0) lat = k;
    end
    chk("midreset_lat", lat, 10);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
